corr_sweep_ctrl: RTL and testbench
==================================

// Module: corr_sweep_ctrl
// PURPOSE
// Downstream controller for CORR_SCORE: steps the correlation window start (oXstart/oYstart) across the frame in a
// raster sweep and drives CORR_SCORE's iControllerReady. Collects oScore after each oFinished and tracks the
// highest score and its coordinates. Reports the best match to the overlay/VGA logic when the sweep completes.
// PARAMETERS
// H_RES        640  frame width in pixels
// V_RES        480  frame height in lines
// SEARCH_H_RES 32   search-template width (CORR_SCORE scans Xcoord 0..SEARCH_H_RES inclusive)
// SEARCH_V_RES 32   search-template height (CORR_SCORE scans Ycoord 0..SEARCH_V_RES inclusive)
// STEP_X       8    X increment between positions, >=1
// STEP_Y       8    Y increment between positions, >=1
// PORTS
// iCLK        in   1   system clock, 50 MHz, shared with CORR_SCORE
// iRST        in   1   synchronous reset, active-high
// iStart      in   1   one-cycle pulse; begins a sweep when idle or done
// iFinished   in   1   from CORR_SCORE oFinished
// iScore      in   32  from CORR_SCORE oScore
// oCorrReady  out  1   to CORR_SCORE iControllerReady
// oXstart     out  13  to CORR_SCORE iXstart
// oYstart     out  13  to CORR_SCORE iYstart
// oBusy       out  1   high while a sweep is in progress
// oDone       out  1   high from end of sweep until next accepted iStart or reset
// oBestX      out  13  X start of best position
// oBestY      out  13  Y start of best position
// oBestScore  out  32  best score
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0. Reset mid-sweep aborts immediately, with no partial result kept.
// - X positions: 0, STEP_X, ... up to the largest multiple <= H_RES-SEARCH_H_RES. Y positions are analogous.
// - Positions are visited in raster order: X runs fastest, then Y.
// - Unsigned 13-bit coordinate arithmetic. Step compare is "next > limit" before any add, so nothing wraps.
// - States:
//   IDLE: ready=0. iStart -> FLUSH; coords:=0, best cleared (score 0, coords 0, valid=0), oDone:=0.
//   FLUSH: ready=1. Waits for iFinished=1, which ends CORR_SCORE's leftover/junk run; that score is discarded.
//     On that edge CORR_SCORE restarts at (0,0). Go to RUN with coords unchanged.
//   RUN: ready=1. iFinished=1 marks completion of the current position.
//     On that edge: prevX/prevY := oXstart/oYstart; advance coords (X:=0 and Y+=STEP_Y at row end).
//     If this was the last position, set a last flag and hold the coords. Go to CAPTURE.
//   CAPTURE: ready=1; one cycle. iScore now holds the score for prev position.
//     Update best if !valid or iScore > oBestScore (strict: ties keep the earliest position); valid:=1.
//     If last -> DONE, else -> RUN.
//   DONE: ready=0, oDone=1, oBusy=0, best outputs held. iStart -> FLUSH as from IDLE.
// - Ready stays high through the final finish edge, so CORR_SCORE latches oScore.
//   Dropping ready afterwards freezes CORR_SCORE mid-run; FLUSH on the next sweep absorbs this.
// - iFinished in CAPTURE cannot occur (CORR_SCORE run >= 2 cycles) and is ignored.
// - iStart while oBusy=1 is ignored. oBusy=1 in FLUSH/RUN/CAPTURE.
// - oXstart/oYstart are registered and change only on a finish edge in RUN, or on an accepted iStart.
// CONFIGURATION
// CORR_EARLY_EXIT_EN defined: adds input iThreshold[31:0]. In CAPTURE, if iScore >= iThreshold, best is forced
//   to that position and the state goes to DONE immediately, even if not last.
// CORR_EARLY_EXIT_EN undefined: iThreshold port absent; every sweep visits all positions.
// TESTING (overrides H_RES=64 V_RES=48 SEARCH_H_RES=16 SEARCH_V_RES=16 STEP_X=STEP_Y=16 -> X{0,16,32,48} x Y{0,16,32}, 12 positions)
// Bench model of CORR_SCORE: fixed run length, score = f(Xstart,Ystart).
// 1) f peak 900 at (32,16), else 100; pulse iStart
//    -> 12 captures in raster order; oDone=1, oBestX=32, oBestY=16, oBestScore=900; oCorrReady=0 after.
// 2) f = 500 everywhere -> oBestX=0, oBestY=0, oBestScore=500 (strict compare).
// 3) Junk run: model returns 999 on the first finish after iStart -> 999 is never reported;
//    best = true max of the 12 real positions.
// 4) iRST for 1 cycle during position 5
//    -> next cycle state IDLE, all outputs 0; a new iStart yields a correct full sweep.
// 5) iStart pulses while oBusy=1 -> ignored; same result and cycle count as case 1.
// 6) CORR_EARLY_EXIT_EN, iThreshold=800, f=850 at (16,0), else 100
//    -> DONE after the 2nd capture; oBestX=16, oBestY=0, oBestScore=850.

Source files
------------

// File: rtl/corr_sweep_ctrl.sv
// Raster-sweep controller for CORR_SCORE: steps the window start, keeps the best score and its position.
// Optional early exit on a score threshold is enabled with `define CORR_EARLY_EXIT_EN.
module corr_sweep_ctrl #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int SEARCH_H_RES = 32,
    parameter int SEARCH_V_RES = 32,
    parameter int STEP_X       = 8,
    parameter int STEP_Y       = 8
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iStart,
    input  logic        iFinished,
    input  logic [31:0] iScore,
`ifdef CORR_EARLY_EXIT_EN
    input  logic [31:0] iThreshold,
`endif
    output logic        oCorrReady,
    output logic [12:0] oXstart,
    output logic [12:0] oYstart,
    output logic        oBusy,
    output logic        oDone,
    output logic [12:0] oBestX,
    output logic [12:0] oBestY,
    output logic [31:0] oBestScore,
    output logic [2:0]  oDbgState
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FLUSH   = 3'd1,
        RUN     = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    // One extra bit so "next > limit" is evaluated without wrapping.
    localparam logic [13:0] X_LIM  = 14'(H_RES - SEARCH_H_RES);
    localparam logic [13:0] Y_LIM  = 14'(V_RES - SEARCH_V_RES);
    localparam logic [13:0] X_STEP = 14'(STEP_X);
    localparam logic [13:0] Y_STEP = 14'(STEP_Y);

    state_t      r_state;
    state_t      w_state_next;
    logic [12:0] r_xstart;
    logic [12:0] r_ystart;
    logic [12:0] r_prev_x;
    logic [12:0] r_prev_y;
    logic [12:0] r_best_x;
    logic [12:0] r_best_y;
    logic [31:0] r_best_score;
    logic        r_valid;
    logic        r_last;
    logic        w_ready;
    logic        w_early;
    logic        w_update;
    logic [13:0] w_x_next;
    logic [13:0] w_y_next;

    assign w_x_next = {1'b0, r_xstart} + X_STEP;
    assign w_y_next = {1'b0, r_ystart} + Y_STEP;

`ifdef CORR_EARLY_EXIT_EN
    assign w_early = (iScore >= iThreshold);
`else
    assign w_early = 1'b0;
`endif

    // Strict compare: equal scores keep the earliest position in raster order.
    assign w_update = w_early || !r_valid || (iScore > r_best_score);

    always_ff @(posedge iCLK) begin
        if (iRST) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        case (r_state)
            IDLE:    if (iStart) w_state_next = FLUSH;
            FLUSH: begin
                w_ready = 1'b1;
                if (iFinished) w_state_next = RUN;
            end
            RUN: begin
                w_ready = 1'b1;
                if (iFinished) w_state_next = CAPTURE;
            end
            CAPTURE: begin
                w_ready      = 1'b1;
                w_state_next = (w_early || r_last) ? DONE : RUN;
            end
            DONE:    if (iStart) w_state_next = FLUSH;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_xstart     <= '0;
            r_ystart     <= '0;
            r_prev_x     <= '0;
            r_prev_y     <= '0;
            r_best_x     <= '0;
            r_best_y     <= '0;
            r_best_score <= '0;
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (iStart) begin
                        r_xstart     <= '0;
                        r_ystart     <= '0;
                        r_best_x     <= '0;
                        r_best_y     <= '0;
                        r_best_score <= '0;
                        r_valid      <= 1'b0;
                        r_last       <= 1'b0;
                    end
                end
                RUN: begin
                    if (iFinished) begin
                        r_prev_x <= r_xstart;
                        r_prev_y <= r_ystart;
                        if (w_x_next <= X_LIM) begin
                            r_xstart <= w_x_next[12:0];
                        end else if (w_y_next <= Y_LIM) begin
                            r_xstart <= '0;
                            r_ystart <= w_y_next[12:0];
                        end else begin
                            r_last <= 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    if (w_update) begin
                        r_best_x     <= r_prev_x;
                        r_best_y     <= r_prev_y;
                        r_best_score <= iScore;
                    end
                    r_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign oCorrReady = w_ready;
    assign oXstart    = r_xstart;
    assign oYstart    = r_ystart;
    assign oBusy      = (r_state == FLUSH) || (r_state == RUN) || (r_state == CAPTURE);
    assign oDone      = (r_state == DONE);
    assign oBestX     = r_best_x;
    assign oBestY     = r_best_y;
    assign oBestScore = r_best_score;
    assign oDbgState  = r_state;

endmodule

// File: tb/tb_corr_sweep_ctrl.sv
// Bench for corr_sweep_ctrl on a 64x48 frame (4x3 positions) with a fixed-length CORR_SCORE model.
// Case 6 is built only when CORR_EARLY_EXIT_EN is defined.
module tb_corr_sweep_ctrl;

  localparam int RUN_LEN = 4;
  localparam int TIMEOUT = 2000;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iStart = 1'b0;
  logic        iFinished;
  logic [31:0] iScore;
`ifdef CORR_EARLY_EXIT_EN
  logic [31:0] iThreshold = 32'hFFFF_FFFF;
`endif
  logic        oCorrReady;
  logic [12:0] oXstart;
  logic [12:0] oYstart;
  logic        oBusy;
  logic        oDone;
  logic [12:0] oBestX;
  logic [12:0] oBestY;
  logic [31:0] oBestScore;
  logic [2:0]  oDbgState;

  corr_sweep_ctrl #(
    .H_RES(64), .V_RES(48), .SEARCH_H_RES(16), .SEARCH_V_RES(16), .STEP_X(16), .STEP_Y(16)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iFinished(iFinished), .iScore(iScore),
`ifdef CORR_EARLY_EXIT_EN
    .iThreshold(iThreshold),
`endif
    .oCorrReady(oCorrReady), .oXstart(oXstart), .oYstart(oYstart), .oBusy(oBusy), .oDone(oDone),
    .oBestX(oBestX), .oBestY(oBestY), .oBestScore(oBestScore), .oDbgState(oDbgState)
  );

  // clock / reset
  always #10 iCLK = ~iCLK;

  // CORR_SCORE model: runs while ready is high, samples the start one cycle into a run,
  // and returns the score of that start together with the finish pulse.
  int          score_mode = 0;
  bit          junk_mode = 1'b0;
  logic [2:0]  m_cnt;
  logic [12:0] m_xs;
  logic [12:0] m_ys;
  logic        m_junk;

  function automatic logic [31:0] f_score(input int mode, input logic [12:0] x, input logic [12:0] y);
    case (mode)
      0:       return (x == 13'd32 && y == 13'd16) ? 32'd900 : 32'd100;
      1:       return 32'd500;
      2:       return 32'(x) + 32'd4 * 32'(y) + 32'd10;
      default: return (x == 13'd16 && y == 13'd0) ? 32'd850 : 32'd100;
    endcase
  endfunction

  always @(posedge iCLK) begin
    if (iRST) begin
      m_cnt     <= '0;
      m_xs      <= '0;
      m_ys      <= '0;
      m_junk    <= 1'b0;
      iFinished <= 1'b0;
      iScore    <= '0;
    end else begin
      if (iStart && !oBusy) m_junk <= 1'b1;
      if (oCorrReady) begin
        if (m_cnt == 3'd1) begin
          m_xs <= oXstart;
          m_ys <= oYstart;
        end
        if (m_cnt == 3'(RUN_LEN - 1)) begin
          iFinished <= 1'b1;
          iScore    <= (m_junk && junk_mode) ? 32'd999 : f_score(score_mode, m_xs, m_ys);
          m_junk    <= 1'b0;
          m_cnt     <= '0;
        end else begin
          iFinished <= 1'b0;
          m_cnt     <= m_cnt + 3'd1;
        end
      end else begin
        iFinished <= 1'b0;
      end
    end
  end

  // monitor: positions completed in RUN and number of CAPTURE cycles
  logic [25:0] obs_q[$];
  int          n_cap = 0;

  always @(negedge iCLK) begin
    if (!iRST) begin
      if (oDbgState == 3'd2 && iFinished) obs_q.push_back({oXstart, oYstart});
      if (oDbgState == 3'd3) n_cap++;
    end
  end

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [25:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic apply_reset();
    @(negedge iCLK);
    iRST = 1'b1;
    repeat (2) @(negedge iCLK);
    iRST = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_state"}, 32'(oDbgState), 32'd0);
    check({tag, "_ready"}, 32'(oCorrReady), 32'd0);
    check({tag, "_xy"}, {6'd0, oXstart, oYstart}, 32'd0);
    check({tag, "_busy_done"}, {30'd0, oBusy, oDone}, 32'd0);
    check({tag, "_best_xy"}, {6'd0, oBestX, oBestY}, 32'd0);
    check({tag, "_best_score"}, oBestScore, 32'd0);
  endtask

  // Pulses iStart, waits for oDone, then checks visit order and capture count.
  task automatic run_sweep(input string tag, input bit extra, input int n_vis, output int cycles);
    int base_obs;
    int base_cap;
    int got;
    base_obs = obs_q.size();
    base_cap = n_cap;
    exp_q.delete();
    for (int i = 0; i < n_vis; i++) exp_q.push_back({13'((i % 4) * 16), 13'((i / 4) * 16)});
    @(negedge iCLK);
    iStart = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0;
    cycles = 1;
    while (!oDone && cycles < TIMEOUT) begin
      iStart = extra && oBusy && (cycles == 5 || cycles == 20 || cycles == 41);
      @(negedge iCLK);
      cycles++;
    end
    iStart = 1'b0;
    check({tag, "_done"}, 32'(oDone), 32'd1);
    check({tag, "_busy"}, 32'(oBusy), 32'd0);
    check({tag, "_ready_off"}, 32'(oCorrReady), 32'd0);
    check({tag, "_captures"}, 32'(n_cap - base_cap), 32'(n_vis));
    got = obs_q.size() - base_obs;
    check({tag, "_visits"}, 32'(got), 32'(n_vis));
    for (int i = 0; i < n_vis && i < got; i++)
      check({tag, "_visit_xy"}, 32'(obs_q[base_obs + i]), 32'(exp_q[i]));
  endtask

  typedef struct {
    int          mode;
    bit          junk;
    bit          extra;
    logic [12:0] bx;
    logic [12:0] by;
    logic [31:0] bs;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int cyc;
    int base_cap;
    int guard;
    int case1_cycles;

    vecs[0] = '{0, 1'b0, 1'b0, 13'd32, 13'd16, 32'd900};
    vecs[1] = '{1, 1'b0, 1'b0, 13'd0,  13'd0,  32'd500};
    vecs[2] = '{2, 1'b1, 1'b0, 13'd48, 13'd32, 32'd186};
    vecs[3] = '{0, 1'b0, 1'b1, 13'd32, 13'd16, 32'd900};
    case1_cycles = 0;

    apply_reset();
    check_idle_zero("reset");

    for (int v = 0; v < 4; v++) begin
      apply_reset();
      score_mode = vecs[v].mode;
      junk_mode  = vecs[v].junk;
      run_sweep($sformatf("vec%0d", v), vecs[v].extra, 12, cyc);
      check($sformatf("vec%0d_best_x", v), 32'(oBestX), 32'(vecs[v].bx));
      check($sformatf("vec%0d_best_y", v), 32'(oBestY), 32'(vecs[v].by));
      check($sformatf("vec%0d_best_score", v), oBestScore, vecs[v].bs);
      check($sformatf("vec%0d_last_xy", v), {6'd0, oXstart, oYstart}, {6'd0, 13'd48, 13'd32});
      @(negedge iCLK);
      check($sformatf("vec%0d_hold_done", v), {30'd0, oDone, oCorrReady}, 32'd2);
      if (v == 0) case1_cycles = cyc;
      if (vecs[v].extra) check("busy_start_cycles", 32'(cyc), 32'(case1_cycles));
    end

    // reset in the middle of position 5, then a clean sweep
    apply_reset();
    score_mode = 0;
    junk_mode  = 1'b0;
    base_cap   = n_cap;
    @(negedge iCLK);
    iStart = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0;
    guard = 0;
    while (n_cap - base_cap < 4 && guard < TIMEOUT) begin
      @(negedge iCLK);
      guard++;
    end
    check("midreset_reach_pos5", 32'(n_cap - base_cap), 32'd4);
    repeat (2) @(negedge iCLK);
    check("midreset_busy_before", 32'(oBusy), 32'd1);
    iRST = 1'b1;
    @(negedge iCLK);
    iRST = 1'b0;
    check_idle_zero("midreset");
    run_sweep("after_reset", 1'b0, 12, cyc);
    check("after_reset_best_xy", {6'd0, oBestX, oBestY}, {6'd0, 13'd32, 13'd16});
    check("after_reset_best_score", oBestScore, 32'd900);
    check("after_reset_cycles", 32'(cyc), 32'(case1_cycles));

`ifdef CORR_EARLY_EXIT_EN
    apply_reset();
    score_mode = 3;
    junk_mode  = 1'b0;
    iThreshold = 32'd800;
    run_sweep("early_exit", 1'b0, 2, cyc);
    check("early_exit_best_xy", {6'd0, oBestX, oBestY}, {6'd0, 13'd16, 13'd0});
    check("early_exit_best_score", oBestScore, 32'd850);
    check("early_exit_held_xy", {6'd0, oXstart, oYstart}, {6'd0, 13'd32, 13'd0});
    iThreshold = 32'hFFFF_FFFF;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
